// File: rtl/spi_1to8_recv.sv
// Serial-to-parallel receiver: assembles DATA_W sampled bits into a word with valid/full/error flags.
// Optional macro SPI_RECV_SYNC_EN adds 2-flop synchronizers on im_data, im_work_en and im_work_pluse.
module spi_1to8_recv #(
    parameter int DATA_W    = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              im_work_en,
    input  logic              im_work_pluse,
    input  logic              im_data,
    input  logic              im_data_ack,
    input  logic              im_err_clr,
    output logic [DATA_W-1:0] om_data,
    output logic              om_data_vld,
    output logic              om_data_full,
    output logic [3:0]        om_bit_cnt,
    output logic              om_frame_err,
    output logic              om_overrun
);

    logic              work_en;
    logic              work_pluse;
    logic              work_data;
    logic              work_en_d;
    logic [3:0]        bit_cnt;
    logic [DATA_W-1:0] sreg;
    logic [DATA_W-1:0] sreg_next;
    logic              capture;
    logic              word_done;
    logic              frame_abort;
    logic              overrun_set;

`ifdef SPI_RECV_SYNC_EN
    logic [1:0] en_sync;
    logic [1:0] pluse_sync;
    logic [1:0] data_sync;

    // All three lines share the same depth so data stays aligned with its strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_sync    <= '0;
            pluse_sync <= '0;
            data_sync  <= '0;
        end else begin
            en_sync    <= {en_sync[0], im_work_en};
            pluse_sync <= {pluse_sync[0], im_work_pluse};
            data_sync  <= {data_sync[0], im_data};
        end
    end

    assign work_en    = en_sync[1];
    assign work_pluse = pluse_sync[1];
    assign work_data  = data_sync[1];
`else
    assign work_en    = im_work_en;
    assign work_pluse = im_work_pluse;
    assign work_data  = im_data;
`endif

    assign capture     = work_en && work_pluse;
    assign word_done   = capture && (bit_cnt == 4'(DATA_W - 1));
    assign frame_abort = !work_en && work_en_d && (bit_cnt != 4'd0);
    // An ack landing with the new word hands the slot over cleanly, so no overrun.
    assign overrun_set = word_done && om_data_full && !im_data_ack;

    always_comb begin
        sreg_next = sreg;
        if (LSB_FIRST) begin
            sreg_next = {work_data, sreg[DATA_W-1:1]};
        end else begin
            sreg_next = {sreg[DATA_W-2:0], work_data};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work_en_d <= 1'b0;
            bit_cnt   <= 4'd0;
            sreg      <= '0;
        end else begin
            work_en_d <= work_en;
            if (!work_en) begin
                bit_cnt <= 4'd0;
                sreg    <= '0;
            end else if (capture) begin
                sreg    <= sreg_next;
                bit_cnt <= word_done ? 4'd0 : bit_cnt + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            om_data      <= '0;
            om_data_vld  <= 1'b0;
            om_data_full <= 1'b0;
        end else begin
            om_data_vld <= word_done;
            if (word_done) begin
                om_data      <= sreg_next;
                om_data_full <= 1'b1;
            end else if (im_data_ack) begin
                om_data_full <= 1'b0;
            end
        end
    end

    // Sticky flags: a set in the same cycle as a clear wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            om_frame_err <= 1'b0;
            om_overrun   <= 1'b0;
        end else begin
            if (frame_abort) begin
                om_frame_err <= 1'b1;
            end else if (im_err_clr) begin
                om_frame_err <= 1'b0;
            end
            if (overrun_set) begin
                om_overrun <= 1'b1;
            end else if (im_err_clr) begin
                om_overrun <= 1'b0;
            end
        end
    end

    assign om_bit_cnt = bit_cnt;

endmodule

// File: tb/tb_spi_1to8_recv.sv
// Bench for spi_1to8_recv: directed vector table, hand-written corner sequences, randomized model run.
module tb_spi_1to8_recv;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       pulse;
    logic       din;
    logic       ack;
    logic       clr;
    logic [7:0] data_l;
    logic       vld_l;
    logic       full_l;
    logic [3:0] cnt_l;
    logic       ferr_l;
    logic       ovr_l;
    logic [7:0] data_m;
    logic       vld_m;
    logic       full_m;
    logic [3:0] cnt_m;
    logic       ferr_m;
    logic       ovr_m;

    int pass_cnt = 0;
    int total_cnt = 0;

    spi_1to8_recv #(.DATA_W(8), .LSB_FIRST(1'b1)) u_lsb (
        .clk(clk), .rst_n(rst_n), .im_work_en(en), .im_work_pluse(pulse),
        .im_data(din), .im_data_ack(ack), .im_err_clr(clr),
        .om_data(data_l), .om_data_vld(vld_l), .om_data_full(full_l),
        .om_bit_cnt(cnt_l), .om_frame_err(ferr_l), .om_overrun(ovr_l)
    );

    spi_1to8_recv #(.DATA_W(8), .LSB_FIRST(1'b0)) u_msb (
        .clk(clk), .rst_n(rst_n), .im_work_en(en), .im_work_pluse(pulse),
        .im_data(din), .im_data_ack(ack), .im_err_clr(clr),
        .om_data(data_m), .om_data_vld(vld_m), .om_data_full(full_m),
        .om_bit_cnt(cnt_m), .om_frame_err(ferr_m), .om_overrun(ovr_m)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] seq;       // seq[i] is the i-th bit on the wire
        logic       ack_pre;
        logic       clr_pre;
        logic       ack_last;
        logic       full_pre;
        logic       ovr_pre;
        logic [7:0] exp_lsb;
        logic [7:0] exp_msb;
        logic       exp_full;
        logic       exp_ovr;
    } vec_t;

    vec_t tbl[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // One clock: drive inputs, take the edge, settle 1 time unit after it.
    task automatic step(input logic e, input logic p, input logic d, input logic a, input logic c);
        en = e; pulse = p; din = d; ack = a; clr = c;
        @(posedge clk);
        #1;
        pulse = 1'b0; ack = 1'b0; clr = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; en = 1'b0; pulse = 1'b0; din = 1'b0; ack = 1'b0; clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // behavioural reference model
    bit   m_bits[$];
    logic [7:0] m_lsb, m_msb;
    logic m_vld, m_full, m_ovr, m_ferr, m_en_prev;

    task automatic model_reset();
        m_bits.delete();
        m_lsb = 8'h00; m_msb = 8'h00;
        m_vld = 1'b0; m_full = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0; m_en_prev = 1'b0;
    endtask

    task automatic model_cycle(input logic e, input logic p, input logic d, input logic a, input logic c);
        logic done, fset, oset;
        int w_l, w_m;
        done = 1'b0; fset = 1'b0; oset = 1'b0;
        if (e && p) begin
            m_bits.push_back(d);
            if (m_bits.size() == 8) begin
                w_l = 0; w_m = 0;
                for (int i = 0; i < 8; i++) begin
                    w_l = w_l + (int'(m_bits[i]) << i);
                    w_m = w_m + (int'(m_bits[i]) << (7 - i));
                end
                m_lsb = 8'(w_l); m_msb = 8'(w_m);
                done = 1'b1;
                m_bits.delete();
            end
        end
        if (!e) begin
            if (m_en_prev && m_bits.size() != 0) fset = 1'b1;
            m_bits.delete();
        end
        m_vld = done;
        if (done) begin
            if (m_full && !a) oset = 1'b1;
            m_full = 1'b1;
        end else if (a) begin
            m_full = 1'b0;
        end
        if (oset) m_ovr = 1'b1; else if (c) m_ovr = 1'b0;
        if (fset) m_ferr = 1'b1; else if (c) m_ferr = 1'b0;
        m_en_prev = e;
    endtask

    initial begin
        logic [7:0] w;
        logic e, p, d, a, c;

        tbl[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 8'hA5, 1'b1, 1'b0};
        tbl[1] = '{8'h03, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h03, 8'hC0, 1'b1, 1'b0};
        tbl[2] = '{8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C, 8'h3C, 1'b1, 1'b0};
        tbl[3] = '{8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h81, 8'h81, 1'b1, 1'b1};
        tbl[4] = '{8'h12, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h12, 8'h48, 1'b1, 1'b0};
        tbl[5] = '{8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, 8'hFF, 1'b1, 1'b0};

        do_reset();
        check("rst_data", data_l, 8'h00);
        check("rst_data_msb", data_m, 8'h00);
        check("rst_vld", vld_l, 1'b0);
        check("rst_full", full_l, 1'b0);
        check("rst_cnt", cnt_l, 4'd0);
        check("rst_ferr", ferr_l, 1'b0);
        check("rst_ovr", ovr_l, 1'b0);

        // vector table
        for (int r = 0; r < 6; r++) begin
            step(1'b1, 1'b0, 1'b0, tbl[r].ack_pre, tbl[r].clr_pre);
            check("tbl_pre_vld", vld_l, 1'b0);
            check("tbl_pre_full", full_l, tbl[r].full_pre);
            check("tbl_pre_ovr", ovr_l, tbl[r].ovr_pre);
            for (int i = 0; i < 8; i++) begin
                step(1'b1, 1'b1, tbl[r].seq[i], (i == 7) ? tbl[r].ack_last : 1'b0, 1'b0);
                if (i < 7) begin
                    check("tbl_cnt", cnt_l, 4'(i + 1));
                    check("tbl_mid_vld", vld_l, 1'b0);
                end else begin
                    check("tbl_vld", vld_l, 1'b1);
                    check("tbl_cnt_wrap", cnt_l, 4'd0);
                    check("tbl_data_lsb", data_l, tbl[r].exp_lsb);
                    check("tbl_data_msb", data_m, tbl[r].exp_msb);
                    check("tbl_full", full_l, tbl[r].exp_full);
                    check("tbl_ovr", ovr_l, tbl[r].exp_ovr);
                end
            end
        end

        // frame abort mid-word, with a pulse coinciding with the enable drop
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        check("abort_pre_full", full_l, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("abort_cnt5", cnt_l, 4'd5);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        check("abort_ferr", ferr_l, 1'b1);
        check("abort_cnt", cnt_l, 4'd0);
        check("abort_data", data_l, 8'hFF);
        check("abort_vld", vld_l, 1'b0);
        w = 8'h5A;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b1, w[i], 1'b0, 1'b0);
            check("refr_vld", vld_l, (i == 7) ? 1'b1 : 1'b0);
        end
        check("refr_data", data_l, 8'h5A);
        check("refr_ferr_sticky", ferr_l, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("vld_one_cycle", vld_l, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        check("clr_ferr", ferr_l, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("drop_at_zero_ferr", ferr_l, 1'b0);

        // set beats clear: overrun and frame error
        w = 8'h77;
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, w[i], 1'b0, (i == 7) ? 1'b1 : 1'b0);
        check("ovr_set_wins", ovr_l, 1'b1);
        check("ovr_data", data_l, 8'h77);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("ferr_set_wins", ferr_l, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("ack_clears_full", full_l, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("ack_idle_full", full_l, 1'b0);
        check("ack_idle_data", data_l, 8'h77);

        // asynchronous reset mid-word
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_data", data_l, 8'h00);
        check("arst_cnt", cnt_l, 4'd0);
        check("arst_ferr", ferr_l, 1'b0);
        check("arst_ovr", ovr_l, 1'b0);
        check("arst_full", full_l, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        w = 8'h35;
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, w[i], 1'b0, 1'b0);
        check("post_rst_lsb", data_l, 8'h35);
        check("post_rst_msb", data_m, 8'hAC);
        check("post_rst_vld", vld_l, 1'b1);

        // randomized run against the model
        do_reset();
        model_reset();
        for (int n = 0; n < 600; n++) begin
            e = ($urandom_range(0, 19) != 0);
            p = 1'($urandom_range(0, 1));
            d = 1'($urandom_range(0, 1));
            a = ($urandom_range(0, 3) == 0);
            c = ($urandom_range(0, 9) == 0);
            model_cycle(e, p, d, a, c);
            step(e, p, d, a, c);
            check("rnd_vld", vld_l, m_vld);
            check("rnd_data_lsb", data_l, m_lsb);
            check("rnd_data_msb", data_m, m_msb);
            check("rnd_full", full_l, m_full);
            check("rnd_cnt", cnt_l, 4'(m_bits.size()));
            check("rnd_ovr", ovr_l, m_ovr);
            check("rnd_ferr", ferr_l, m_ferr);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/spi_1to8_recv.md
Name: spi_1to8_recv

Overview:
- Receive-side counterpart of the layer-3 8-to-1 send serializer.
- Samples one serial bit per work pulse while the frame enable is high, and assembles DATA_W bits into a parallel word.
- Presents each word with a one-cycle valid strobe and a held "full" flag until acknowledged.
- Flags frames aborted mid-word and words overwritten before acknowledgement.
- Sits between the SPI pin/timing layer (which generates the sample pulse) and the byte-level protocol layer.

Parameters:
- DATA_W, 8: bits per word; legal range 2..16.
- LSB_FIRST, 1: 1 = first received bit lands in bit 0 (matches the send serializer); 0 = first bit lands in bit DATA_W-1.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- im_work_en  input  1  frame enable (chip-select level, active high).
- im_work_pluse  input  1  one-clk sample strobe; im_data is sampled on the edge where this is high.
- im_data  input  1  serial data in.
- im_data_ack  input  1  one-clk pulse from consumer; clears om_data_full.
- im_err_clr  input  1  one-clk pulse; clears the sticky error flags.
- om_data  output  DATA_W  last completed word.
- om_data_vld  output  1  one-clk strobe, high the cycle after a word completes.
- om_data_full  output  1  word held and not yet acknowledged.
- om_bit_cnt  output  4  bits received in the current word (0..DATA_W-1).
- om_frame_err  output  1  sticky: enable dropped with a partial word.
- om_overrun  output  1  sticky: word completed while om_data_full was still 1.

Behaviour:
- Reset values (async, rst_n=0):
  - om_data=0, om_data_vld=0, om_data_full=0.
  - om_bit_cnt=0, internal shift register=0.
  - om_frame_err=0, om_overrun=0.
- Idle state (im_work_en=0):
  - bit counter and shift register held at 0; pulses ignored.
  - om_data, om_data_full and the error flags are retained.
- Capture (im_work_en=1 and im_work_pluse=1):
  - LSB_FIRST=1: shift register <= {im_data, sreg[DATA_W-1:1]}.
  - LSB_FIRST=0: shift register <= {sreg[DATA_W-2:0], im_data}.
  - Bit counter increments.
- Word completion (capture with bit counter == DATA_W-1):
  - Same edge: om_data <= the fully assembled word, including the current bit.
  - Same edge: bit counter wraps to 0 and om_data_vld <= 1.
  - om_data_vld is high for exactly one cycle.
  - Latency: last sample edge to om_data/om_data_vld visible is 1 clk.
- Back-to-back words in one frame:
  - No gap is required; a sample on the clk right after completion starts the next word.
- Full/ack handshake:
  - Completion sets om_data_full.
  - im_data_ack clears om_data_full unless a completion occurs in the same cycle; in that case om_data_full stays 1 and no overrun is flagged.
  - An ack while om_data_full=0 has no effect.
- Overrun:
  - Completion while om_data_full=1 and no ack that cycle sets om_overrun=1.
  - om_data is still overwritten with the newest word.
- Frame abort:
  - Falling edge of im_work_en (im_work_en=0 with previous cycle 1) while bit counter != 0 sets om_frame_err=1.
  - Partial word is discarded; counter and shift register cleared; om_data is unchanged.
  - A pulse coinciding with im_work_en=0 is ignored.
  - Enable falling with bit counter == 0 is not an error.
- Error clear:
  - im_err_clr clears both sticky flags.
  - If a set condition occurs in the same cycle, set wins.
- Reset mid-word: all state returns immediately to the reset values.

Optional Feature:
- Macro: SPI_RECV_SYNC_EN.
- Defined:
  - im_data, im_work_en and im_work_pluse each pass through an aligned 2-flop synchronizer (reset value 0) before any other logic.
  - All latencies grow by 2 clk.
  - Pulses must be separated by ≥3 clk.
  - im_data_ack and im_err_clr are not synchronized.
- Not defined: inputs are used directly; latencies are as stated above.

Test Plan:
- LSB_FIRST=1; en=1; 8 pulses carrying bits 1,0,1,0,0,1,0,1 → om_data=8'hA5; om_data_vld high 1 clk after the 8th pulse; om_data_full=1; om_bit_cnt back to 0.
- LSB_FIRST=0, same bit sequence → om_data=8'hA5 reversed to 8'hA5's mirror 8'hA5→8'hA5? No: first bit → bit7, so om_data=8'hA5 bit-reversed = 8'hA5 (palindrome); rerun with 1,1,0,0,0,0,0,0 → 8'hC0 (vs 8'h03 with LSB_FIRST=1).
- Two consecutive words 8'h3C then 8'h81 with no ack → om_overrun=1, om_data=8'h81; then im_err_clr → om_overrun=0 while om_data_full stays 1.
- Ack in the same cycle as the second completion → om_data_full stays 1, om_overrun=0; a further ack → om_data_full=0.
- 5 pulses, then en dropped → om_frame_err=1, om_bit_cnt=0, om_data unchanged; new frame of 8 bits 8'hFF → om_data=8'hFF, no leftover bits.
- rst_n asserted after 3 bits → all outputs 0 asynchronously; next full frame decodes correctly. With SPI_RECV_SYNC_EN defined, case 1 gives om_data_vld 3 clk after the 8th pulse.
